// File: rtl/adc_modulation.sv
// -----------------------------------------------------------------------------
// adc_modulation
// Multislope run-up ADC controller. A rising edge on adc_measure_trig_i while
// idle starts a conversion: integrator reset, signal run-up with per-cycle
// reference steering from the comparator sign, rundown to a comparator
// crossing (or timeout), then publication of the counts and valid.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   p_clk_count_reset_i          integrator reset length in clocks (0 -> 1)
//   p_clk_count_aperture_i       signal integration length in clocks
//   p_clk_count_cycle_i          run-up cycle length in clocks (0 -> 1)
//   p_clk_count_rundown_max_i    rundown timeout in clocks
//   adc_measure_trig_i           start request (rising edge while idle)
//   cmpr_i                       raw asynchronous comparator, 1 = positive
//   adc_measure_valid_o          result valid / idle level
//   refmux_o                     [0] REF_POS [1] REF_NEG [2] INT_RESET [3] SIG_EN
//   cmpr_latch_o                 1 = comparator held, 0 = transparent
//   count_pos_o / count_neg_o    run-up cycles with REF_POS / REF_NEG applied
//   count_rundown_o              rundown clocks
//   count_sig_o                  signal integration clocks
//   overflow_o                   last rundown timed out
//   monitor_o                    {state[2:0], cmpr_sync}
// -----------------------------------------------------------------------------
module adc_modulation #(
  parameter int CW = 24
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [CW-1:0] p_clk_count_reset_i,
  input  logic [CW-1:0] p_clk_count_aperture_i,
  input  logic [CW-1:0] p_clk_count_cycle_i,
  input  logic [CW-1:0] p_clk_count_rundown_max_i,
  input  logic          adc_measure_trig_i,
  input  logic          cmpr_i,
  output logic          adc_measure_valid_o,
  output logic [3:0]    refmux_o,
  output logic          cmpr_latch_o,
  output logic [CW-1:0] count_pos_o,
  output logic [CW-1:0] count_neg_o,
  output logic [CW-1:0] count_rundown_o,
  output logic [CW-1:0] count_sig_o,
  output logic          overflow_o,
  output logic [3:0]    monitor_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_SIG     = 3'd2,
    ST_RUNDOWN = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [3:0]    REFMUX_RST = 4'b0100;
  localparam logic [3:0]    REFMUX_POS = 4'b0001;
  localparam logic [3:0]    REFMUX_NEG = 4'b0010;
  localparam logic [3:0]    REFMUX_SIG = 4'b1000;
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

  // Saturating increment used by every counter.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  state_t        r_state;
  logic          r_cmpr_meta;
  logic          r_cmpr_sync;
  logic          r_trig_d;
  logic          r_valid;
  logic [3:0]    r_refmux;
  logic          r_latch;
  logic [CW-1:0] r_phase;
  logic [CW-1:0] r_cnt_pos;
  logic [CW-1:0] r_cnt_neg;
  logic [CW-1:0] r_cnt_sig;
  logic [CW-1:0] r_cnt_rd;
  logic          r_rd_dir;
  logic          r_ovf_int;
  logic [CW-1:0] r_out_pos;
  logic [CW-1:0] r_out_neg;
  logic [CW-1:0] r_out_rd;
  logic [CW-1:0] r_out_sig;
  logic          r_out_ovf;

  logic [CW-1:0] w_reset_len;
  logic [CW-1:0] w_cycle_len;
  logic [CW-1:0] w_phase_next;
  logic [CW-1:0] w_sig_next;
  logic [CW-1:0] w_rd_next;
  logic          w_start;
  logic          w_boundary;
  logic          w_sig_exit;
  logic [3:0]    w_dir_mux;

  assign w_reset_len  = (p_clk_count_reset_i == CNT_ZERO) ? CNT_ONE : p_clk_count_reset_i;
  assign w_cycle_len  = (p_clk_count_cycle_i == CNT_ZERO) ? CNT_ONE : p_clk_count_cycle_i;
  // r_phase never exceeds len-1, so this increment cannot wrap.
  assign w_phase_next = r_phase + CNT_ONE;
  assign w_sig_next   = sat_inc(r_cnt_sig);
  assign w_rd_next    = sat_inc(r_cnt_rd);
  assign w_start      = adc_measure_trig_i & ~r_trig_d & (r_state == ST_IDLE);
  assign w_boundary   = (w_phase_next >= w_cycle_len);
  // A saturated signal counter also terminates run-up at the boundary.
  assign w_sig_exit   = (w_sig_next >= p_clk_count_aperture_i) | (w_sig_next == CNT_MAX);
  // Positive integrator is pushed back with the negative reference.
  assign w_dir_mux    = r_cmpr_sync ? REFMUX_NEG : REFMUX_POS;

  assign adc_measure_valid_o = r_valid;
  assign refmux_o            = r_refmux;
  assign cmpr_latch_o        = r_latch;
  assign count_pos_o         = r_out_pos;
  assign count_neg_o         = r_out_neg;
  assign count_rundown_o     = r_out_rd;
  assign count_sig_o         = r_out_sig;
  assign overflow_o          = r_out_ovf;
  assign monitor_o           = {r_state, r_cmpr_sync};

  // Comparator synchronizer and trigger edge history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmpr_meta <= 1'b0;
      r_cmpr_sync <= 1'b0;
      // Starts high so a trigger held through reset is not taken as an edge.
      r_trig_d    <= 1'b1;
    end else begin
      r_cmpr_meta <= cmpr_i;
      r_cmpr_sync <= r_cmpr_meta;
      r_trig_d    <= adc_measure_trig_i;
    end
  end

  // Conversion sequencer with registered mux, latch, valid and result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_valid   <= 1'b1;
      r_refmux  <= REFMUX_RST;
      r_latch   <= 1'b1;
      r_phase   <= CNT_ZERO;
      r_cnt_pos <= CNT_ZERO;
      r_cnt_neg <= CNT_ZERO;
      r_cnt_sig <= CNT_ZERO;
      r_cnt_rd  <= CNT_ZERO;
      r_rd_dir  <= 1'b0;
      r_ovf_int <= 1'b0;
      r_out_pos <= CNT_ZERO;
      r_out_neg <= CNT_ZERO;
      r_out_rd  <= CNT_ZERO;
      r_out_sig <= CNT_ZERO;
      r_out_ovf <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_valid  <= 1'b1;
          r_refmux <= REFMUX_RST;
          r_latch  <= 1'b1;
          if (w_start) begin
            r_valid   <= 1'b0;
            r_phase   <= CNT_ZERO;
            r_cnt_pos <= CNT_ZERO;
            r_cnt_neg <= CNT_ZERO;
            r_cnt_sig <= CNT_ZERO;
            r_cnt_rd  <= CNT_ZERO;
            r_ovf_int <= 1'b0;
            r_state   <= ST_RESET;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_RESET: begin
          if (w_phase_next >= w_reset_len) begin
            r_phase <= CNT_ZERO;
            r_latch <= 1'b0;
            if (p_clk_count_aperture_i == CNT_ZERO) begin
              // Zero aperture: skip run-up entirely.
              r_rd_dir <= r_cmpr_sync;
              r_refmux <= w_dir_mux;
              r_state  <= ST_RUNDOWN;
            end else begin
              // First cycle boundary is the entry into run-up.
              r_refmux <= REFMUX_SIG | w_dir_mux;
              if (r_cmpr_sync) begin
                r_cnt_neg <= sat_inc(r_cnt_neg);
              end else begin
                r_cnt_pos <= sat_inc(r_cnt_pos);
              end
              r_state <= ST_SIG;
            end
          end else begin
            r_phase <= w_phase_next;
          end
        end

        ST_SIG: begin
          r_cnt_sig <= w_sig_next;
          if (w_boundary) begin
            r_phase <= CNT_ZERO;
            if (w_sig_exit) begin
              r_rd_dir <= r_cmpr_sync;
              r_refmux <= w_dir_mux;
              r_state  <= ST_RUNDOWN;
            end else begin
              r_refmux <= REFMUX_SIG | w_dir_mux;
              if (r_cmpr_sync) begin
                r_cnt_neg <= sat_inc(r_cnt_neg);
              end else begin
                r_cnt_pos <= sat_inc(r_cnt_pos);
              end
            end
          end else begin
            r_phase <= w_phase_next;
          end
        end

        ST_RUNDOWN: begin
          r_cnt_rd <= w_rd_next;
          if (r_cmpr_sync != r_rd_dir) begin
            r_ovf_int <= 1'b0;
            r_refmux  <= REFMUX_RST;
            r_latch   <= 1'b1;
            r_state   <= ST_DONE;
          end else if (w_rd_next >= p_clk_count_rundown_max_i) begin
            r_ovf_int <= 1'b1;
            r_refmux  <= REFMUX_RST;
            r_latch   <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_state <= ST_RUNDOWN;
          end
        end

        ST_DONE: begin
          r_out_pos <= r_cnt_pos;
          r_out_neg <= r_cnt_neg;
          r_out_rd  <= r_cnt_rd;
          r_out_sig <= r_cnt_sig;
          r_out_ovf <= r_ovf_int;
          r_valid   <= 1'b1;
          r_state   <= ST_IDLE;
        end

        default: begin
          r_refmux <= REFMUX_RST;
          r_latch  <= 1'b1;
          r_valid  <= 1'b1;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_modulation.sv
module tb_adc_modulation;
  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [CW-1:0] p_reset, p_ap, p_cyc, p_rdmax;
  logic          trig, cmpr;
  logic          valid, latch, ovf;
  logic [3:0]    refmux, monitor;
  logic [CW-1:0] c_pos, c_neg, c_rd, c_sig;

  int n_cmp = 0;
  int n_bad = 0;

  // Comparator waveform, indexed by clock edge relative to the trigger edge.
  bit wave [0:4095];

  // Counts the bench expects to be on the outputs between conversions.
  int pub_pos, pub_neg, pub_rd, pub_sig;
  bit pub_ovf;

  always #5 clk = ~clk;

  adc_modulation #(.CW(CW)) dut (
    .clk                       (clk),
    .reset_n                   (reset_n),
    .p_clk_count_reset_i       (p_reset),
    .p_clk_count_aperture_i    (p_ap),
    .p_clk_count_cycle_i       (p_cyc),
    .p_clk_count_rundown_max_i (p_rdmax),
    .adc_measure_trig_i        (trig),
    .cmpr_i                    (cmpr),
    .adc_measure_valid_o       (valid),
    .refmux_o                  (refmux),
    .cmpr_latch_o              (latch),
    .count_pos_o               (c_pos),
    .count_neg_o               (c_neg),
    .count_rundown_o           (c_rd),
    .count_sig_o               (c_sig),
    .overflow_o                (ovf),
    .monitor_o                 (monitor)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Comparator value the controller acts on at edge k (two-clock synchronizer).
  function automatic bit sync_at(input int k);
    return wave[(k < 2) ? 0 : k - 2];
  endfunction

  task automatic fill_random(input int flip_div);
    bit v;
    v = 1'($urandom_range(0, 1));
    for (int j = 0; j < 4096; j++) begin
      if ($urandom_range(0, flip_div - 1) == 0) v = ~v;
      wave[j] = v;
    end
  endtask

  // Reference model: timeline of one conversion from the spec's rules.
  task automatic model(input int r, a, c, rdmax,
                       output int reff, ceff, s, d, pos, neg, sig, rd,
                       output bit rd_dir, output bit ovf_m);
    int  ncyc;
    bit  fin;
    reff = (r == 0) ? 1 : r;
    ceff = (c == 0) ? 1 : c;
    pos = 0; neg = 0; sig = 0;
    if (a != 0) begin
      ncyc = (a + ceff - 1) / ceff;
      for (int i = 0; i < ncyc; i++) begin
        if (sync_at(reff + i * ceff)) neg++;
        else pos++;
      end
      sig = ncyc * ceff;
    end
    s = reff + sig;
    rd_dir = sync_at(s);
    rd = 0; ovf_m = 1'b0; fin = 1'b0;
    while (!fin) begin
      rd++;
      if (sync_at(s + rd) != rd_dir) fin = 1'b1;
      else if (rd >= rdmax) begin ovf_m = 1'b1; fin = 1'b1; end
    end
    d = s + rd;
  endtask

  // Runs one full conversion, checking every clock and the published result.
  task automatic run_conv(input int r, a, c, rdmax, input bit retrig, input string tag);
    int reff, ceff, s, d, pos, neg, sig, rd, bad, first_bad, i;
    bit rd_dir, ovf_m, dir, exp_valid, exp_latch;
    logic [3:0] exp_ref;
    model(r, a, c, rdmax, reff, ceff, s, d, pos, neg, sig, rd, rd_dir, ovf_m);
    p_reset = CW'(r); p_ap = CW'(a); p_cyc = CW'(c); p_rdmax = CW'(rdmax);
    @(negedge clk);
    trig = 1'b0; cmpr = wave[0];
    @(negedge clk);
    @(negedge clk);
    bad = 0; first_bad = -1;
    for (int k = 0; k <= d + 1; k++) begin
      cmpr = wave[k];
      if (k == 0) trig = 1'b1;
      if (retrig && k == reff + 3) trig = 1'b0;
      if (retrig && k == reff + 6) trig = 1'b1;
      @(posedge clk);
      #1;
      exp_valid = (k == d + 1);
      if (k < reff) begin
        exp_ref = 4'b0100; exp_latch = 1'b1;
      end else if (k < s) begin
        i = (k - reff) / ceff;
        dir = sync_at(reff + i * ceff);
        exp_ref = dir ? 4'b1010 : 4'b1001; exp_latch = 1'b0;
      end else if (k < d) begin
        exp_ref = rd_dir ? 4'b0010 : 4'b0001; exp_latch = 1'b0;
      end else begin
        exp_ref = 4'b0100; exp_latch = 1'b1;
      end
      if (refmux !== exp_ref || valid !== exp_valid || latch !== exp_latch ||
          (k <= d && (c_pos !== CW'(pub_pos) || c_neg !== CW'(pub_neg) ||
                      c_rd !== CW'(pub_rd) || c_sig !== CW'(pub_sig) || ovf !== pub_ovf))) begin
        if (first_bad < 0) first_bad = k;
        bad++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL %s_trace: %0d bad cycles (first at edge %0d), required 0", tag, bad, first_bad);
    end
    pub_pos = pos; pub_neg = neg; pub_rd = rd; pub_sig = sig; pub_ovf = ovf_m;
    n_cmp++; if (c_pos !== CW'(pos)) begin n_bad++; $display("FAIL %s_pos: got %0d want %0d", tag, c_pos, pos); end
    n_cmp++; if (c_neg !== CW'(neg)) begin n_bad++; $display("FAIL %s_neg: got %0d want %0d", tag, c_neg, neg); end
    n_cmp++; if (c_sig !== CW'(sig)) begin n_bad++; $display("FAIL %s_sig: got %0d want %0d", tag, c_sig, sig); end
    n_cmp++; if (c_rd !== CW'(rd)) begin n_bad++; $display("FAIL %s_rundown: got %0d want %0d", tag, c_rd, rd); end
    n_cmp++; if (ovf !== ovf_m) begin n_bad++; $display("FAIL %s_overflow: got %0b want %0b", tag, ovf, ovf_m); end
    n_cmp++; if (monitor[3:1] !== 3'd0) begin n_bad++; $display("FAIL %s_state_idle: got %0d want 0", tag, monitor[3:1]); end
    // Trigger is still high here: no new conversion may start.
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (valid !== 1'b1 || refmux !== 4'b0100) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin n_bad++; $display("FAIL %s_no_restart: %0d bad cycles, required 0", tag, bad); end
  endtask

  task automatic check_reset_values(input string tag);
    n_cmp++;
    if (valid !== 1'b1 || refmux !== 4'b0100 || latch !== 1'b1 || ovf !== 1'b0 ||
        c_pos !== '0 || c_neg !== '0 || c_rd !== '0 || c_sig !== '0 || monitor[3:1] !== 3'd0) begin
      n_bad++;
      $display("FAIL %s: valid=%0b refmux=%b latch=%0b ovf=%0b pos=%0d neg=%0d rd=%0d sig=%0d st=%0d, required 1 0100 1 0 0 0 0 0 0",
               tag, valid, refmux, latch, ovf, c_pos, c_neg, c_rd, c_sig, monitor[3:1]);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; trig = 1'b0; cmpr = 1'b0;
    p_reset = '0; p_ap = '0; p_cyc = '0; p_rdmax = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_reset_values("reset");
    pub_pos = 0; pub_neg = 0; pub_rd = 0; pub_sig = 0; pub_ovf = 1'b0;
  endtask

  task automatic test_alternation();
    int s;
    s = 10 + 1000;
    for (int j = 0; j < 4096; j++) begin
      if (j < s - 2) wave[j] = 1'((j / 100) & 1);
      else if (j < s + 35) wave[j] = 1'b1;
      else wave[j] = 1'b0;
    end
    run_conv(10, 1000, 100, 2000, 1'b0, "alternation");
    n_cmp++; if (c_pos + c_neg !== CW'(10)) begin n_bad++; $display("FAIL alt_cycles: got %0d want 10", c_pos + c_neg); end
    n_cmp++; if (c_pos !== CW'(5)) begin n_bad++; $display("FAIL alt_balance: got %0d want 5", c_pos); end
    n_cmp++; if (c_sig !== CW'(1000)) begin n_bad++; $display("FAIL alt_sig: got %0d want 1000", c_sig); end
    n_cmp++; if (c_rd !== CW'(37)) begin n_bad++; $display("FAIL alt_rundown37: got %0d want 37", c_rd); end
  endtask

  task automatic test_rounding();
    fill_random(40);
    run_conv(5, 950, 100, 600, 1'b0, "round950");
    n_cmp++; if (c_sig !== CW'(1000)) begin n_bad++; $display("FAIL round_sig: got %0d want 1000", c_sig); end
    n_cmp++; if (c_pos + c_neg !== CW'(10)) begin n_bad++; $display("FAIL round_cycles: got %0d want 10", c_pos + c_neg); end
    fill_random(20);
    run_conv(0, 0, 0, 300, 1'b0, "aperture0");
    n_cmp++; if (c_sig !== '0 || c_pos !== '0 || c_neg !== '0) begin
      n_bad++; $display("FAIL ap0_zero: sig=%0d pos=%0d neg=%0d want 0 0 0", c_sig, c_pos, c_neg);
    end
  endtask

  task automatic test_timeout();
    for (int j = 0; j < 4096; j++) wave[j] = 1'b1;
    run_conv(3, 200, 50, 500, 1'b0, "timeout");
    n_cmp++; if (c_rd !== CW'(500) || ovf !== 1'b1) begin
      n_bad++; $display("FAIL timeout_500: rd=%0d ovf=%0b want 500 1", c_rd, ovf);
    end
  endtask

  task automatic test_back_to_back();
    fill_random(30);
    run_conv(10, 1000, 100, 400, 1'b1, "retrig");
    fill_random(30);
    run_conv(2, 120, 7, 200, 1'b0, "fresh_edge");
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      fill_random(int'($urandom_range(4, 40)));
      run_conv(int'($urandom_range(0, 20)), int'($urandom_range(0, 400)),
               int'($urandom_range(0, 40)), int'($urandom_range(1, 300)), 1'b0, "random");
    end
  endtask

  task automatic test_async_reset();
    fill_random(10);
    p_reset = CW'(4); p_ap = CW'(300); p_cyc = CW'(30); p_rdmax = CW'(200);
    @(negedge clk);
    trig = 1'b0; cmpr = wave[0];
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      cmpr = wave[k];
      if (k == 0) trig = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (refmux[3] !== 1'b1 || valid !== 1'b0) begin
      n_bad++; $display("FAIL async_pre_sig: refmux=%b valid=%0b want 1xxx 0", refmux, valid);
    end
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    pub_pos = 0; pub_neg = 0; pub_rd = 0; pub_sig = 0; pub_ovf = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("after_async_release");
    trig = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alternation();
    test_rounding();
    test_timeout();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_modulation.md
Name: adc_modulation

Overview:
- Multislope run-up ADC controller that sits directly downstream of sample_acquisition_az. It replaces adc_test on the same trigger/valid handshake.
- On a trigger it resets the integrator, then integrates the signal for the aperture. During that time it steers the reference current mux each fixed-length cycle according to comparator sign.
- It then runs down to a comparator crossing, publishes the counts, and asserts valid.
- Counts are read by the MCU through register_set. The refmux and latch outputs go to the mode mux (adc_refmux_o, adc_cmpr_latch_o).

Parameters:
- CW, 24, width of all counters and count parameters.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- p_clk_count_reset_i  in  CW  integrator-reset duration, clocks.
- p_clk_count_aperture_i  in  CW  signal integration duration, clocks.
- p_clk_count_cycle_i  in  CW  run-up cycle length, clocks (0 treated as 1).
- p_clk_count_rundown_max_i  in  CW  rundown timeout, clocks.
- adc_measure_trig_i  in  1  start request from sample_acquisition_az.
- cmpr_i  in  1  raw asynchronous comparator output; 1 = integrator positive.
- adc_measure_valid_o  out  1  result valid / idle level.
- refmux_o  out  4  [0] REF_POS, [1] REF_NEG, [2] INT_RESET, [3] SIG_EN.
- cmpr_latch_o  out  1  1 = comparator latched (hold), 0 = transparent.
- count_pos_o, count_neg_o  out  CW  run-up cycles with REF_POS / REF_NEG applied.
- count_rundown_o  out  CW  rundown clocks.
- count_sig_o  out  CW  actual signal-integration clocks.
- overflow_o  out  1  rundown timed out on last conversion.
- monitor_o  out  4  {state[2:0], cmpr_sync}.

Behaviour:
- Reset values:
  - state IDLE.
  - adc_measure_valid_o = 1.
  - refmux_o = 4'b0100 (integrator held reset).
  - cmpr_latch_o = 1.
  - All count outputs = 0; overflow_o = 0.
- cmpr_i passes through a 2-flop synchronizer (cmpr_sync). All decisions use cmpr_sync; latency is 2 clocks, and it is not compensated.
- Trigger is edge-detected: a start fires on a 0→1 transition of adc_measure_trig_i seen while in IDLE. Edges seen in any other state are ignored, with no queuing.
- IDLE:
  - refmux 4'b0100, valid 1.
  - On start: valid ← 0 in the next cycle, all internal counters cleared, go to RESET.
- RESET:
  - refmux 4'b0100 for p_clk_count_reset_i clocks (0 means 1 clock), then go to SIG.
- SIG (run-up):
  - SIG_EN = 1, cmpr_latch_o = 0.
  - At each cycle boundary (entry, then every p_clk_count_cycle_i clocks), sample cmpr_sync:
    - 1 → REF_NEG for the whole cycle, count_neg += 1;
    - 0 → REF_POS for the whole cycle, count_pos += 1.
  - REF_POS and REF_NEG are never both 1.
  - count_sig increments every clock in SIG.
  - Exit only at a cycle boundary where count_sig ≥ p_clk_count_aperture_i, so count_sig is the aperture rounded up to a whole number of cycles.
  - If the aperture is 0, SIG lasts zero clocks and both counts stay 0.
- RUNDOWN:
  - SIG_EN = 0.
  - Latch the direction at entry: cmpr_sync = 1 → REF_NEG; 0 → REF_POS.
  - count_rundown increments every clock.
  - Exit when cmpr_sync differs from the value latched at entry → DONE with overflow = 0.
  - Or exit when count_rundown reaches p_clk_count_rundown_max_i → DONE with overflow = 1.
- DONE (1 clock):
  - refmux 4'b0100, cmpr_latch_o = 1.
  - Copy the internal counters to the output registers.
  - Assert valid in the following cycle, then go to IDLE.
  - Output counts change only in DONE and are stable whenever valid = 1.
- Counter overflow:
  - run-up counters saturate at all-ones;
  - count_sig saturating forces an exit from SIG at the next boundary.
- reset_n asserted mid-conversion returns to the reset values immediately. Partial counts are discarded and never published.
- Parameter inputs are sampled continuously. The MCU changes them only while valid = 1.

Test Plan:
- Reset held, then released with trig = 0 → valid = 1, refmux = 4'b0100, all counts 0, monitor state IDLE.
- Run-up alternation: reset = 10, aperture = 1000, cycle = 100, cmpr_i toggled every cycle, rundown crossing after 37 clocks:
  - valid falls 1 clock after the trig edge;
  - refmux = 0100 for 10 clocks;
  - count_pos + count_neg = 10 and count_sig = 1000;
  - count_rundown = 37 (± sync latency, checked exactly against the model);
  - overflow = 0; valid rises after DONE.
- Aperture rounding: aperture = 950, cycle = 100 → count_sig = 1000, 10 cycles. Aperture = 0 → count_sig = 0 and both run-up counts 0.
- Rundown timeout: rundown_max = 500, cmpr_i held constant → count_rundown = 500, overflow = 1, valid asserts.
- Handshake robustness:
  - a second trig edge mid-SIG is ignored (a single conversion);
  - trig held high across DONE does not restart;
  - a fresh edge after valid does start a new conversion.
- Async reset asserted mid-SIG → outputs revert to reset values within 0 clocks; the previously published counts are cleared to 0.
